// File: rtl/e203_exu_wbck_arb.sv
// Writeback arbiter between the ALU and long-pipe writeback paths.
// Drives the integer and FPU regfile write ports through one register stage.
module e203_exu_wbck_arb #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned RFIDX_W    = 5,
  parameter int unsigned STARVE_MAX = 4,
  parameter int unsigned STARVE_W   = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               alu_wbck_i_valid,
  output logic               alu_wbck_i_ready,
  input  logic [XLEN-1:0]    alu_wbck_i_wdat,
  input  logic [RFIDX_W-1:0] alu_wbck_i_rdidx,
  input  logic               longp_wbck_i_valid,
  output logic               longp_wbck_i_ready,
  input  logic [XLEN-1:0]    longp_wbck_i_wdat,
  input  logic [4:0]         longp_wbck_i_flags,
  input  logic [RFIDX_W-1:0] longp_wbck_i_rdidx,
  input  logic               longp_wbck_i_rdfpu,
  output logic               rf_wbck_o_ena,
  output logic [XLEN-1:0]    rf_wbck_o_wdat,
  output logic [RFIDX_W-1:0] rf_wbck_o_rdidx,
  output logic               frf_wbck_o_ena,
  output logic [XLEN-1:0]    frf_wbck_o_wdat,
  output logic [RFIDX_W-1:0] frf_wbck_o_rdidx,
  output logic               fflags_o_ena,
  output logic [4:0]         fflags_o
);

  localparam int unsigned FLAG_W = 5;

  logic [STARVE_W-1:0] starve_cnt_q, starve_cnt_d;
  logic                lp_int, force_alu, alu_hs, lp_hs;

  logic               rf_ena_q, rf_ena_d;
  logic [XLEN-1:0]    rf_wdat_q, rf_wdat_d;
  logic [RFIDX_W-1:0] rf_rdidx_q, rf_rdidx_d;
  logic               frf_ena_q, frf_ena_d;
  logic [XLEN-1:0]    frf_wdat_q, frf_wdat_d;
  logic [RFIDX_W-1:0] frf_rdidx_q, frf_rdidx_d;
  logic               ff_ena_q, ff_ena_d;
  logic [FLAG_W-1:0]  ff_q, ff_d;

  // Grants: long-pipe wins integer-port conflicts unless the ALU has starved.
  always_comb begin
    lp_int             = longp_wbck_i_valid & ~longp_wbck_i_rdfpu;
    force_alu          = (starve_cnt_q == STARVE_W'(STARVE_MAX));
    alu_wbck_i_ready   = rst_n & (~lp_int | force_alu);
    longp_wbck_i_ready = rst_n & (longp_wbck_i_rdfpu | ~(alu_wbck_i_valid & force_alu));
    alu_hs             = alu_wbck_i_valid & alu_wbck_i_ready;
    lp_hs              = longp_wbck_i_valid & longp_wbck_i_ready;
  end

  // Starvation counter and next writeback register contents.
  always_comb begin
    starve_cnt_d = '0;
    rf_ena_d     = 1'b0;
    rf_wdat_d    = rf_wdat_q;
    rf_rdidx_d   = rf_rdidx_q;
    frf_ena_d    = 1'b0;
    frf_wdat_d   = frf_wdat_q;
    frf_rdidx_d  = frf_rdidx_q;
    ff_ena_d     = 1'b0;
    ff_d         = ff_q;

    if (alu_wbck_i_valid & ~alu_wbck_i_ready) begin
      starve_cnt_d = force_alu ? starve_cnt_q : starve_cnt_q + STARVE_W'(1);
    end

    if (alu_hs) begin
      rf_ena_d   = (alu_wbck_i_rdidx != '0);
      rf_wdat_d  = alu_wbck_i_wdat;
      rf_rdidx_d = alu_wbck_i_rdidx;
    end

    if (lp_hs) begin
      ff_ena_d = 1'b1;
      ff_d     = longp_wbck_i_flags;
      if (longp_wbck_i_rdfpu) begin
        frf_ena_d   = 1'b1;
        frf_wdat_d  = longp_wbck_i_wdat;
        frf_rdidx_d = longp_wbck_i_rdidx;
      end else begin
        rf_ena_d   = (longp_wbck_i_rdidx != '0);
        rf_wdat_d  = longp_wbck_i_wdat;
        rf_rdidx_d = longp_wbck_i_rdidx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt_q <= '0;
      rf_ena_q     <= 1'b0;
      rf_wdat_q    <= '0;
      rf_rdidx_q   <= '0;
      frf_ena_q    <= 1'b0;
      frf_wdat_q   <= '0;
      frf_rdidx_q  <= '0;
      ff_ena_q     <= 1'b0;
      ff_q         <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      rf_ena_q     <= rf_ena_d;
      rf_wdat_q    <= rf_wdat_d;
      rf_rdidx_q   <= rf_rdidx_d;
      frf_ena_q    <= frf_ena_d;
      frf_wdat_q   <= frf_wdat_d;
      frf_rdidx_q  <= frf_rdidx_d;
      ff_ena_q     <= ff_ena_d;
      ff_q         <= ff_d;
    end
  end

  assign rf_wbck_o_ena    = rf_ena_q;
  assign rf_wbck_o_wdat   = rf_wdat_q;
  assign rf_wbck_o_rdidx  = rf_rdidx_q;
  assign frf_wbck_o_ena   = frf_ena_q;
  assign frf_wbck_o_wdat  = frf_wdat_q;
  assign frf_wbck_o_rdidx = frf_rdidx_q;
  assign fflags_o_ena     = ff_ena_q;
  assign fflags_o         = ff_q;

endmodule

// File: tb/tb_e203_exu_wbck_arb.sv
// Bench for e203_exu_wbck_arb: vector table, starvation/reset sequences,
// and a randomized run against a transaction-level reference model.
module tb_e203_exu_wbck_arb;

  localparam int SMAX = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        alu_v, alu_rdy, lp_v, lp_rdy, lp_fpu;
  logic [31:0] alu_dat, lp_dat;
  logic [4:0]  alu_idx, lp_idx, lp_flags;
  logic        rf_ena, frf_ena, ff_ena;
  logic [31:0] rf_dat, frf_dat;
  logic [4:0]  rf_idx, frf_idx, ff;

  int n_chk = 0;
  int n_fail = 0;

  // reference model state
  int          m_den;
  logic        m_rf_ena, m_frf_ena, m_ff_ena;
  logic [31:0] m_rf_dat, m_frf_dat;
  logic [4:0]  m_rf_idx, m_frf_idx, m_ff;

  always #5 clk = ~clk;

  e203_exu_wbck_arb #(.XLEN(32), .RFIDX_W(5), .STARVE_MAX(SMAX), .STARVE_W(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_wbck_i_valid(alu_v), .alu_wbck_i_ready(alu_rdy),
    .alu_wbck_i_wdat(alu_dat), .alu_wbck_i_rdidx(alu_idx),
    .longp_wbck_i_valid(lp_v), .longp_wbck_i_ready(lp_rdy),
    .longp_wbck_i_wdat(lp_dat), .longp_wbck_i_flags(lp_flags),
    .longp_wbck_i_rdidx(lp_idx), .longp_wbck_i_rdfpu(lp_fpu),
    .rf_wbck_o_ena(rf_ena), .rf_wbck_o_wdat(rf_dat), .rf_wbck_o_rdidx(rf_idx),
    .frf_wbck_o_ena(frf_ena), .frf_wbck_o_wdat(frf_dat), .frf_wbck_o_rdidx(frf_idx),
    .fflags_o_ena(ff_ena), .fflags_o(ff)
  );

  typedef struct {
    logic        av; logic [4:0] ai; logic [31:0] ad;
    logic        lv; logic lf; logic [4:0] li; logic [31:0] ld; logic [4:0] fl;
    logic        e_ardy, e_lrdy;
    logic        e_rf_ena; logic [4:0] e_rf_idx; logic [31:0] e_rf_dat;
    logic        e_frf_ena; logic [4:0] e_frf_idx; logic [31:0] e_frf_dat;
    logic        e_ff_ena; logic [4:0] e_ff;
  } vec_t;

  vec_t vt[8];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_outs(input string tag, input logic re, input logic [4:0] ri,
                          input logic [31:0] rd, input logic fe, input logic [4:0] fi,
                          input logic [31:0] fd, input logic ge, input logic [4:0] g);
    chk({tag, ".rf_ena"}, 64'(rf_ena), 64'(re));
    chk({tag, ".rf_idx"}, 64'(rf_idx), 64'(ri));
    chk({tag, ".rf_dat"}, 64'(rf_dat), 64'(rd));
    chk({tag, ".frf_ena"}, 64'(frf_ena), 64'(fe));
    chk({tag, ".frf_idx"}, 64'(frf_idx), 64'(fi));
    chk({tag, ".frf_dat"}, 64'(frf_dat), 64'(fd));
    chk({tag, ".ff_ena"}, 64'(ff_ena), 64'(ge));
    chk({tag, ".ff"}, 64'(ff), 64'(g));
  endtask

  task automatic idle_inputs();
    alu_v = 0; alu_idx = 0; alu_dat = 0;
    lp_v = 0; lp_fpu = 0; lp_idx = 0; lp_dat = 0; lp_flags = 0;
  endtask

  task automatic do_reset();
    @(negedge clk); rst_n = 0; idle_inputs();
    @(negedge clk); rst_n = 1;
  endtask

  task automatic model_reset();
    m_den = 0;
    m_rf_ena = 0; m_rf_dat = 0; m_rf_idx = 0;
    m_frf_ena = 0; m_frf_dat = 0; m_frf_idx = 0;
    m_ff_ena = 0; m_ff = 0;
  endtask

  // Expected grants from the arbitration rules and the denial streak.
  function automatic logic m_alu_rdy();
    if (!rst_n) return 1'b0;
    return !(lp_v && !lp_fpu) || (m_den == SMAX);
  endfunction

  function automatic logic m_lp_rdy();
    if (!rst_n) return 1'b0;
    return lp_fpu || !(alu_v && m_den == SMAX);
  endfunction

  task automatic model_clock();
    logic ar, lr;
    ar = m_alu_rdy(); lr = m_lp_rdy();
    m_rf_ena = 0; m_frf_ena = 0; m_ff_ena = 0;
    if (alu_v && ar) begin
      m_rf_ena = (alu_idx != 0); m_rf_idx = alu_idx; m_rf_dat = alu_dat;
    end
    if (lp_v && lr) begin
      m_ff_ena = 1; m_ff = lp_flags;
      if (lp_fpu) begin
        m_frf_ena = 1; m_frf_idx = lp_idx; m_frf_dat = lp_dat;
      end else begin
        m_rf_ena = (lp_idx != 0); m_rf_idx = lp_idx; m_rf_dat = lp_dat;
      end
    end
    if (alu_v && !ar) m_den = (m_den < SMAX) ? m_den + 1 : SMAX;
    else m_den = 0;
  endtask

  initial begin
    rst_n = 0;
    idle_inputs();
    // ALU-only, FP pair, x0 writes, integer conflicts, idle
    vt[0] = '{1,5,32'hDEADBEEF, 0,0,0,0,0, 1,1, 1,5,32'hDEADBEEF, 0,0,0, 0,0};
    vt[1] = '{1,3,32'h1234, 1,1,7,32'hCAFE,5'h11, 1,1, 1,3,32'h1234, 1,7,32'hCAFE, 1,5'h11};
    vt[2] = '{1,0,32'h4444, 0,0,0,0,0, 1,1, 0,0,32'h4444, 0,0,0, 0,0};
    vt[3] = '{0,0,0, 1,1,0,32'h55,5'h0, 1,1, 0,0,0, 1,0,32'h55, 1,0};
    vt[4] = '{0,0,0, 1,0,9,32'h77,5'h3, 0,1, 1,9,32'h77, 0,0,0, 1,5'h3};
    vt[5] = '{1,4,32'hAA, 1,0,6,32'hBB,5'h1, 0,1, 1,6,32'hBB, 0,0,0, 1,5'h1};
    vt[6] = '{0,0,0, 0,0,0,0,0, 1,1, 0,0,0, 0,0,0, 0,0};
    vt[7] = '{0,0,0, 1,0,0,32'h99,5'h1F, 0,1, 0,0,32'h99, 0,0,0, 1,5'h1F};

    #2;
    chk("reset.alu_rdy", 64'(alu_rdy), 64'(0));
    chk("reset.lp_rdy", 64'(lp_rdy), 64'(0));
    chk_outs("reset", 0,0,0, 0,0,0, 0,0);

    for (int i = 0; i < 8; i++) begin
      do_reset();
      alu_v = vt[i].av; alu_idx = vt[i].ai; alu_dat = vt[i].ad;
      lp_v = vt[i].lv; lp_fpu = vt[i].lf; lp_idx = vt[i].li;
      lp_dat = vt[i].ld; lp_flags = vt[i].fl;
      #1;
      chk($sformatf("vec%0d.alu_rdy", i), 64'(alu_rdy), 64'(vt[i].e_ardy));
      chk($sformatf("vec%0d.lp_rdy", i), 64'(lp_rdy), 64'(vt[i].e_lrdy));
      @(posedge clk); #1;
      chk_outs($sformatf("vec%0d", i), vt[i].e_rf_ena, vt[i].e_rf_idx, vt[i].e_rf_dat,
               vt[i].e_frf_ena, vt[i].e_frf_idx, vt[i].e_frf_dat, vt[i].e_ff_ena, vt[i].e_ff);
      @(negedge clk); idle_inputs(); #1;
      @(posedge clk); #1;
      chk($sformatf("vec%0d.rf_ena_drop", i), 64'(rf_ena), 64'(0));
      chk($sformatf("vec%0d.ff_ena_drop", i), 64'(ff_ena), 64'(0));
    end

    // Sustained ALU vs integer long-pipe conflict: ALU wins every 5th cycle.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      alu_v = 1; alu_idx = 5'd1; alu_dat = 32'hA000 + 32'(i);
      lp_v = 1; lp_fpu = 0; lp_idx = 5'd2; lp_dat = 32'hB000 + 32'(i); lp_flags = 5'h2;
      #1;
      chk($sformatf("starve%0d.alu_rdy", i), 64'(alu_rdy), 64'((i % 5) == 4));
      chk($sformatf("starve%0d.lp_rdy", i), 64'(lp_rdy), 64'((i % 5) != 4));
      @(posedge clk); #1;
      if ((i % 5) == 4) begin
        chk($sformatf("starve%0d.rf_dat", i), 64'(rf_dat), 64'(32'hA000 + 32'(i)));
        chk($sformatf("starve%0d.ff_ena", i), 64'(ff_ena), 64'(0));
      end else begin
        chk($sformatf("starve%0d.rf_dat", i), 64'(rf_dat), 64'(32'hB000 + 32'(i)));
        chk($sformatf("starve%0d.ff_ena", i), 64'(ff_ena), 64'(1));
      end
    end

    // Reset in the middle of a conflict after three denials.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      alu_v = 1; alu_idx = 5'd1; alu_dat = 32'h1111;
      lp_v = 1; lp_fpu = 0; lp_idx = 5'd2; lp_dat = 32'h2222; lp_flags = 5'h4;
    end
    @(posedge clk); #1;
    chk("rstmid.pre_rf_ena", 64'(rf_ena), 64'(1));
    @(negedge clk); rst_n = 0; #1;
    chk("rstmid.alu_rdy", 64'(alu_rdy), 64'(0));
    chk("rstmid.lp_rdy", 64'(lp_rdy), 64'(0));
    chk_outs("rstmid", 0,0,0, 0,0,0, 0,0);
    @(negedge clk); rst_n = 1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk($sformatf("rstmid%0d.alu_rdy", i), 64'(alu_rdy), 64'(i == 4));
      @(negedge clk);
    end

    // Randomized run against the reference model.
    do_reset();
    model_reset();
    for (int c = 0; c < 5000; c++) begin
      @(negedge clk);
      rst_n = ($urandom_range(0, 63) != 0);
      alu_v = ($urandom_range(0, 3) != 0);
      alu_idx = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      alu_dat = $urandom;
      lp_v = ($urandom_range(0, 3) != 0);
      lp_fpu = ($urandom_range(0, 2) == 0);
      lp_idx = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      lp_dat = $urandom;
      lp_flags = 5'($urandom);
      if (!rst_n) model_reset();
      #1;
      chk("rand.alu_rdy", 64'(alu_rdy), 64'(m_alu_rdy()));
      chk("rand.lp_rdy", 64'(lp_rdy), 64'(m_lp_rdy()));
      chk_outs("rand.neg", m_rf_ena, m_rf_idx, m_rf_dat, m_frf_ena, m_frf_idx,
               m_frf_dat, m_ff_ena, m_ff);
      @(posedge clk);
      if (rst_n) model_clock();
      #1;
      chk_outs("rand.pos", m_rf_ena, m_rf_idx, m_rf_dat, m_frf_ena, m_frf_idx,
               m_frf_dat, m_ff_ena, m_ff);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
